// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings and controller state enumeration
// shared by the load/store read-modify-write controller.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LD,
        RMW_RD,
        WR,
        RESP,
        ERR
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/half lane extract with sign/zero extension for loads,
// and lane merge into an old word for read-modify-write stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] merge_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata_i[7:0];
        case (addr_lo_i)
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            2'd3:    lane_b = rdata_i[31:24];
            default: lane_b = rdata_i[7:0];
        endcase
    end

    assign lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        ld_data_o = rdata_i;
        if (size_i == SZ_BYTE) begin
            ld_data_o = {{24{lane_b[7] & ~unsigned_i}}, lane_b};
        end else if (size_i == SZ_HALF) begin
            ld_data_o = {{16{lane_h[15] & ~unsigned_i}}, lane_h};
        end
    end

    // Only the addressed lane is replaced; the rest keeps the old word.
    always_comb begin
        st_data_o = merge_i;
        if (size_i == SZ_BYTE) begin
            st_data_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (size_i == SZ_HALF) begin
            st_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end else begin
            st_data_o = wdata_i;
        end
    end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// lsu_rmw_ctrl: single-outstanding load/store controller with byte/half RMW.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses (else forced aligned).
module lsu_rmw_ctrl
    import lsu_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_done,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Bus_addr,
    output logic        Bus_we,
    output logic [31:0] Bus_wdata,
    input  logic [31:0] Bus_rdata
);

    state_t      state_q, state_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q, size_n;
    logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
    logic [31:0] addr_n;
    logic [31:0] ld_data, st_data;
    logic        accept, is_word, is_half, trap;

    assign accept  = req_valid & req_ready;
    assign is_word = req_size[1];
    assign is_half = (req_size == SZ_HALF);
    assign size_n  = is_word ? SZ_WORD : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    assign misal  = (is_half & req_addr[0]) |
                    (is_word & (req_addr[1:0] != 2'b00));
    assign trap   = misal;
    assign addr_n = req_addr;
`else
    assign trap   = 1'b0;
    assign addr_n = {req_addr[31:2],
                     is_word ? 2'b00 : {req_addr[1], req_addr[0] & ~is_half}};
`endif

    lsu_lane_align u_lane (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .rdata_i    (Bus_rdata),
        .wdata_i    (wdata_q),
        .merge_i    (merge_q),
        .ld_data_o  (ld_data),
        .st_data_o  (st_data)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (trap)         state_d = ERR;
                    else if (!req_we) state_d = LD;
                    else if (is_word) state_d = WR;
                    else              state_d = RMW_RD;
                end
            end
            LD:      state_d = RESP;
            RMW_RD:  state_d = WR;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= size_n;
                addr_q  <= addr_n;
                wdata_q <= req_wdata;
            end
            if (state_q == LD) begin
                rdata_q <= ld_data;
            end
            if (state_q == RMW_RD) begin
                merge_q <= Bus_rdata;
            end
        end
    end

    // Reset gates every output so nothing leaks while the state register settles.
    always_comb begin
        req_ready = 1'b0;
        rsp_done  = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        Bus_addr  = '0;
        Bus_we    = 1'b0;
        Bus_wdata = '0;
        if (!cpu_rst) begin
            unique case (state_q)
                IDLE: req_ready = 1'b1;
                LD, RMW_RD: Bus_addr = {addr_q[31:2], 2'b00};
                WR: begin
                    Bus_addr  = {addr_q[31:2], 2'b00};
                    Bus_we    = 1'b1;
                    Bus_wdata = st_data;
                end
                RESP: begin
                    rsp_done  = 1'b1;
                    rsp_rdata = we_q ? 32'h0 : rdata_q;
                end
                ERR: begin
                    rsp_done = 1'b1;
                    rsp_err  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// tb_lsu_rmw_ctrl: directed bench with a cycle-level expectation model
// and a word-addressed memory behind the bridge port.
module tb_lsu_rmw_ctrl;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_done, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
    logic        Bus_we;

    always #5 clk = ~clk;

    lsu_rmw_ctrl dut (
        .cpu_clk      (clk),
        .cpu_rst      (cpu_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_done     (rsp_done),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .Bus_addr     (Bus_addr),
        .Bus_we       (Bus_we),
        .Bus_wdata    (Bus_wdata),
        .Bus_rdata    (Bus_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    logic [31:0] mem [0:63];
    bit          preloaded = 1'b0;
    int          we_cnt = 0;

    assign Bus_rdata = mem[Bus_addr[7:2]];

    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[4]  = 32'hDEADBEEF;
            mem[8]  = 32'h11223344;
            mem[12] = 32'h55667788;
            preloaded = 1'b1;
        end else if (Bus_we) begin
            mem[Bus_addr[7:2]] = Bus_wdata;
            we_cnt++;
        end
    end

    typedef struct packed {
        logic        ready;
        logic        done;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] baddr;
        logic        bwe;
        logic [31:0] bwdata;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(logic rdy, logic dn, logic er, logic [31:0] rd,
                                logic [31:0] ba, logic we, logic [31:0] wd);
        exp_t e;
        e.ready = rdy; e.done = dn; e.err = er; e.rdata = rd;
        e.baddr = ba; e.bwe = we; e.bwdata = wd;
        return e;
    endfunction

    // Expected cycle-by-cycle outputs for the request being accepted now.
    function automatic void model_accept();
        logic [1:0]  sz;
        logic [31:0] a, wa, old, v, m, nw;
        int          sh;
        bit          mis;
        sz  = req_size[1] ? 2'd2 : req_size;
        a   = req_addr;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
`endif
        wa  = {a[31:2], 2'b00};
        old = mem[a[7:2]];
        sh  = 8 * int'(a[1:0]);
        m   = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        if (mis) begin
            q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        end else if (!req_we) begin
            if (sz == 2'd2) begin
                v = old;
            end else begin
                v = (old >> sh) & m;
                if (!req_unsigned && v > (m >> 1)) v = v | ~m;
            end
            q.push_back(mk(0, 0, 0, 0, wa, 0, 0));
            q.push_back(mk(0, 1, 0, v, 0, 0, 0));
        end else if (sz == 2'd2) begin
            q.push_back(mk(0, 0, 0, 0, wa, 1, req_wdata));
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        end else begin
            m  = m << sh;
            nw = (old & ~m) | ((req_wdata << sh) & m);
            q.push_back(mk(0, 0, 0, 0, wa, 0, 0));
            q.push_back(mk(0, 0, 0, 0, wa, 1, nw));
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        e = '0;
        if (cpu_rst) q.delete();
        else if (q.size() != 0) e = q.pop_front();
        else e.ready = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(e.ready));
        chk("rsp_done",  32'(rsp_done),  32'(e.done));
        chk("rsp_err",   32'(rsp_err),   32'(e.err));
        chk("rsp_rdata", rsp_rdata,      e.rdata);
        chk("Bus_addr",  Bus_addr,       e.baddr);
        chk("Bus_we",    32'(Bus_we),    32'(e.bwe));
        chk("Bus_wdata", Bus_wdata,      e.bwdata);
        if (!cpu_rst && e.ready && req_valid) model_accept();
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0; rd = '0; er = 1'b0; lat = 0;
        @(posedge clk); #1;
        req_we = we; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_done) begin
                rd = rsp_rdata; er = rsp_err; lat = i;
                break;
            end
        end
        if (lat == 0) begin
            n_chk++; n_fail++;
            $display("FAIL req_timeout: no rsp_done for addr 0x%08h", a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, w0, k, dn;
        cpu_rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 cpu_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        do_req(0, 2'b10, 0, 32'h10, 0, rd, er, lat);
        chk("ld_word_data", rd, 32'hDEADBEEF);
        chk("ld_word_lat", lat, 2);

        w0 = we_cnt;
        do_req(1, 2'b10, 0, 32'h10, 32'h80112233, rd, er, lat);
        chk("st_word_lat", lat, 2);
        chk("st_word_mem", mem[4], 32'h80112233);
        chk("st_word_rdata", rd, 32'h0);

        do_req(0, 2'b00, 0, 32'h13, 0, rd, er, lat);
        chk("ld_sbyte_data", rd, 32'hFFFFFF80);
        do_req(0, 2'b00, 1, 32'h13, 0, rd, er, lat);
        chk("ld_ubyte_data", rd, 32'h00000080);
        chk("ld_ubyte_lat", lat, 2);

        w0 = we_cnt;
        do_req(1, 2'b01, 0, 32'h22, 32'h0000ABCD, rd, er, lat);
        chk("st_half_lat", lat, 3);
        chk("st_half_mem", mem[8], 32'hABCD3344);
        chk("st_half_pulses", we_cnt - w0, 1);

        do_req(0, 2'b10, 0, 32'h21, 0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_lat", lat, 1);
        chk("mis_rdata", rd, 32'h0);
`else
        chk("mis_err", 32'(er), 32'd0);
        chk("mis_lat", lat, 2);
        chk("mis_rdata", rd, 32'hABCD3344);
`endif

        // back-to-back with req_valid held high through the busy cycles
        @(posedge clk); #1;
        req_we = 0; req_size = 2'b10; req_unsigned = 0;
        req_addr = 32'h10; req_valid = 1'b1;
        k = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_done) begin k = i; rd = rsp_rdata; break; end
        end
        chk("b2b_first_data", rd, 32'h80112233);
        chk("b2b_first_k", k, 3);
        @(posedge clk); #1;
        req_size = 2'b01; req_addr = 32'h12;
        k = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rsp_done) begin k = i; rd = rsp_rdata; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_second_data", rd, 32'hFFFF8011);
        chk("b2b_second_gap", k, 3);

        do_req(0, 2'b11, 0, 32'h10, 0, rd, er, lat);
        chk("ld_size11_data", rd, 32'h80112233);
        do_req(0, 2'b01, 1, 32'h12, 0, rd, er, lat);
        chk("ld_uhalf_data", rd, 32'h00008011);
        do_req(1, 2'b00, 0, 32'h31, 32'h0000005A, rd, er, lat);
        chk("st_byte_mem", mem[12], 32'h55665A88);
        chk("st_byte_lat", lat, 3);

        // reset while the byte store sits in its read phase
        w0 = we_cnt;
        @(posedge clk); #1;
        req_we = 1; req_size = 2'b00; req_unsigned = 0;
        req_addr = 32'h30; req_wdata = 32'hEE; req_valid = 1'b1;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (req_ready) k = i;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        cpu_rst = 1'b1;
        @(posedge clk); #1;
        cpu_rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_done) dn++;
        end
        chk("rst_abort_done", dn, 0);
        chk("rst_abort_pulses", we_cnt - w0, 0);
        chk("rst_abort_mem", mem[12], 32'h55665A88);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
